// File: rtl/bus_data_arbiter.sv
// Slot-bus data arbiter: synchronises bus-side inputs, drives read data from the
// lowest-index selected source after a settle window, and commits write cycles.
module bus_data_arbiter #(
    parameter int unsigned NSRC        = 2,
    parameter int unsigned DW          = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned SETTLE      = 2,
    parameter int unsigned TURN        = 3
) (
    input  logic               clk_100m,
    input  logic               reset,
    input  logic               rw,
    input  logic               q3,
    input  logic [NSRC-1:0]    sel_n,
    input  logic [NSRC-1:0]    src_rd_ok,
    input  logic [NSRC*DW-1:0] src_data,
    input  logic [DW-1:0]      data_in,
    output logic [DW-1:0]      data_out,
    output logic               data_oe,
    output logic               en245_n,
    output logic               wr_strobe,
    output logic [DW-1:0]      wr_data,
    output logic [NSRC-1:0]    wr_src,
    output logic               conflict,
    input  logic               conflict_clr
);

    localparam int unsigned IW = (NSRC > 1) ? $clog2(NSRC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DRIVE, S_TURN} state_t;

    logic [SYNC_STAGES-1:0] r_rw_sync;
    logic [SYNC_STAGES-1:0] r_q3_sync;
    logic [NSRC-1:0]        r_sel_sync [SYNC_STAGES];
    logic [NSRC-1:0]        r_ok_sync  [SYNC_STAGES];
    logic [DW-1:0]          r_din_sync [SYNC_STAGES];

    logic            w_rw;
    logic            w_q3;
    logic [NSRC-1:0] w_sel_n;
    logic [NSRC-1:0] w_rd_ok;
    logic [DW-1:0]   w_data_in;

    // Inactive levels on reset keep the bus quiet until real inputs propagate.
    always_ff @(posedge clk_100m or posedge reset) begin
        if (reset) begin
            r_rw_sync <= '1;
            r_q3_sync <= '1;
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sel_sync[s] <= '1;
                r_ok_sync[s]  <= '0;
                r_din_sync[s] <= '0;
            end
        end else begin
            r_rw_sync     <= {r_rw_sync[SYNC_STAGES-2:0], rw};
            r_q3_sync     <= {r_q3_sync[SYNC_STAGES-2:0], q3};
            r_sel_sync[0] <= sel_n;
            r_ok_sync[0]  <= src_rd_ok;
            r_din_sync[0] <= data_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sel_sync[s] <= r_sel_sync[s-1];
                r_ok_sync[s]  <= r_ok_sync[s-1];
                r_din_sync[s] <= r_din_sync[s-1];
            end
        end
    end

    assign w_rw      = r_rw_sync[SYNC_STAGES-1];
    assign w_q3      = r_q3_sync[SYNC_STAGES-1];
    assign w_sel_n   = r_sel_sync[SYNC_STAGES-1];
    assign w_rd_ok   = r_ok_sync[SYNC_STAGES-1];
    assign w_data_in = r_din_sync[SYNC_STAGES-1];

    logic            w_any_sel;
    logic            w_multi_sel;
    logic [IW-1:0]   w_act_idx;
    logic [NSRC-1:0] w_act_onehot;

    always_comb begin
        w_any_sel    = 1'b0;
        w_multi_sel  = 1'b0;
        w_act_idx    = '0;
        w_act_onehot = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (!w_sel_n[i]) begin
                if (w_any_sel) begin
                    w_multi_sel = 1'b1;
                end else begin
                    w_act_idx = IW'(i);
                end
                w_any_sel = 1'b1;
            end
        end
        if (w_any_sel) begin
            w_act_onehot[w_act_idx] = 1'b1;
        end
    end

    state_t        r_state, w_state_nxt;
    logic [IW-1:0] r_idx, w_idx_nxt;
    logic [3:0]    r_cnt, w_cnt_nxt;
    logic          r_data_oe, w_oe_nxt;
    logic [DW-1:0] r_data_out, w_dout_nxt;
    logic          r_en245_n, w_en245_nxt;
    logic          w_qual;
    logic          w_hold;

    assign w_qual = w_rw & w_any_sel & w_rd_ok[w_act_idx];
    assign w_hold = w_rw & ~w_sel_n[r_idx] & w_rd_ok[r_idx];

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (w_qual) begin
                    w_state_nxt = S_SETTLE;
                    w_idx_nxt   = w_act_idx;
                    w_cnt_nxt   = 4'(SETTLE - 1);
                end
            end
            S_SETTLE: begin
                if (!w_qual || (w_act_idx != r_idx)) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_state_nxt = S_DRIVE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_DRIVE: begin
                if (!w_hold) begin
                    if (TURN == 0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_TURN;
                        w_cnt_nxt   = 4'(TURN - 1);
                    end
                end
            end
            S_TURN: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_oe_nxt    = (w_state_nxt == S_DRIVE) & w_rw;
        w_dout_nxt  = w_oe_nxt ? src_data[w_idx_nxt*DW +: DW] : '0;
        w_en245_nxt = ~(((r_state == S_DRIVE) & ~w_q3) | (~w_rw & w_any_sel & ~w_q3));
    end

    always_ff @(posedge clk_100m or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_data_oe  <= 1'b0;
            r_data_out <= '0;
            r_en245_n  <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_cnt      <= w_cnt_nxt;
            r_data_oe  <= w_oe_nxt;
            r_data_out <= w_dout_nxt;
            r_en245_n  <= w_en245_nxt;
        end
    end

    logic            r_wr_arm;
    logic [DW-1:0]   r_cap_data;
    logic [NSRC-1:0] r_cap_src;
    logic            r_wr_strobe;
    logic [DW-1:0]   r_wr_data;
    logic [NSRC-1:0] r_wr_src;
    logic            r_conflict;
    logic            w_wr_cond;
    logic            w_commit;

    // Arm on a low-q3 write cycle; commit on the first clock that ends it.
    assign w_wr_cond = ~w_q3 & ~w_rw & w_any_sel;
    assign w_commit  = r_wr_arm & (w_q3 | ~w_any_sel);

    always_ff @(posedge clk_100m or posedge reset) begin
        if (reset) begin
            r_wr_arm    <= 1'b0;
            r_cap_data  <= '0;
            r_cap_src   <= '0;
            r_wr_strobe <= 1'b0;
            r_wr_data   <= '0;
            r_wr_src    <= '0;
            r_conflict  <= 1'b0;
        end else begin
            r_wr_arm    <= w_wr_cond;
            r_wr_strobe <= w_commit;
            if (~w_rw & w_any_sel) begin
                r_cap_data <= w_data_in;
                r_cap_src  <= w_act_onehot;
            end
            if (w_commit) begin
                r_wr_data <= r_cap_data;
                r_wr_src  <= r_cap_src;
            end
            r_conflict <= w_multi_sel | (r_conflict & ~conflict_clr);
        end
    end

    assign data_out  = r_data_out;
    assign data_oe   = r_data_oe;
    assign en245_n   = r_en245_n;
    assign wr_strobe = r_wr_strobe;
    assign wr_data   = r_wr_data;
    assign wr_src    = r_wr_src;
    assign conflict  = r_conflict;

endmodule

// File: tb/tb_bus_data_arbiter.sv
// Directed bench for bus_data_arbiter: read latency, turnaround, write commit,
// conflict flag, glitch rejection and reset during drive.
module tb_bus_data_arbiter;

    logic        clk_100m = 1'b0;
    logic        reset;
    logic        rw;
    logic        q3;
    logic [1:0]  sel_n;
    logic [1:0]  src_rd_ok;
    logic [15:0] src_data;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        data_oe;
    logic        en245_n;
    logic        wr_strobe;
    logic [7:0]  wr_data;
    logic [1:0]  wr_src;
    logic        conflict;
    logic        conflict_clr;

    int n_run  = 0;
    int n_fail = 0;

    bus_data_arbiter #(
        .NSRC(2), .DW(8), .SYNC_STAGES(2), .SETTLE(2), .TURN(3)
    ) dut (
        .clk_100m    (clk_100m),
        .reset       (reset),
        .rw          (rw),
        .q3          (q3),
        .sel_n       (sel_n),
        .src_rd_ok   (src_rd_ok),
        .src_data    (src_data),
        .data_in     (data_in),
        .data_out    (data_out),
        .data_oe     (data_oe),
        .en245_n     (en245_n),
        .wr_strobe   (wr_strobe),
        .wr_data     (wr_data),
        .wr_src      (wr_src),
        .conflict    (conflict),
        .conflict_clr(conflict_clr)
    );

    always #5 clk_100m = ~clk_100m;

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk_100m);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; rw = 1'b1; q3 = 1'b1; sel_n = 2'b11; src_rd_ok = 2'b00;
        src_data = 16'h0000; data_in = 8'h00; conflict_clr = 1'b0;
        step(3);
        n_run++; if (data_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b want 0", data_oe); end
        n_run++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", data_out); end
        n_run++; if (en245_n !== 1'b1) begin n_fail++; $display("FAIL reset_en245: got %b want 1", en245_n); end
        n_run++; if (wr_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got %b want 0", wr_strobe); end
        n_run++; if (wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wrdata: got %h want 00", wr_data); end
        n_run++; if (wr_src !== 2'b00) begin n_fail++; $display("FAIL reset_wrsrc: got %b want 00", wr_src); end
        n_run++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL reset_conflict: got %b want 0", conflict); end
        reset = 1'b0;
        step(3);
    endtask

    task automatic test_read_latency();
        src_rd_ok = 2'b01; src_data = 16'h00A5; q3 = 1'b0; sel_n = 2'b10;
        for (int e = 1; e <= 5; e++) begin
            step(1);
            n_run++;
            if (data_oe !== (e == 5)) begin
                n_fail++; $display("FAIL read_lat_oe edge %0d: got %b want %b", e, data_oe, (e == 5));
            end
        end
        n_run++; if (data_out !== 8'hA5) begin n_fail++; $display("FAIL read_dout: got %h want A5", data_out); end
        src_data = 16'h005A;
        step(1);
        n_run++; if (data_out !== 8'h5A) begin n_fail++; $display("FAIL read_track: got %h want 5A", data_out); end
        step(1);
        n_run++; if (en245_n !== 1'b0) begin n_fail++; $display("FAIL read_en245: got %b want 0", en245_n); end
    endtask

    task automatic test_release_turn();
        logic exp_oe;
        sel_n = 2'b11;
        for (int e = 1; e <= 9; e++) begin
            step(1);
            exp_oe = (e < 3) || (e >= 9);
            n_run++;
            if (data_oe !== exp_oe) begin
                n_fail++; $display("FAIL turn_oe edge %0d: got %b want %b", e, data_oe, exp_oe);
            end
            if (e == 3) begin
                n_run++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL turn_dout0: got %h want 00", data_out); end
                sel_n = 2'b10;
            end
        end
        n_run++; if (data_out !== 8'h5A) begin n_fail++; $display("FAIL turn_redrive: got %h want 5A", data_out); end
        sel_n = 2'b11; q3 = 1'b1;
        step(10);
    endtask

    task automatic test_write_commit();
        int strobes;
        logic [7:0] got_data;
        logic [1:0] got_src;
        strobes = 0; got_data = 8'h00; got_src = 2'b00;
        src_rd_ok = 2'b00; rw = 1'b0; sel_n = 2'b01; q3 = 1'b0; data_in = 8'h3C;
        step(4);
        n_run++; if (en245_n !== 1'b0) begin n_fail++; $display("FAIL wr_en245: got %b want 0", en245_n); end
        n_run++; if (wr_strobe !== 1'b0) begin n_fail++; $display("FAIL wr_early_strobe: got %b want 0", wr_strobe); end
        q3 = 1'b1;
        for (int e = 0; e < 8; e++) begin
            step(1);
            if (wr_strobe) begin strobes++; got_data = wr_data; got_src = wr_src; end
        end
        n_run++; if (strobes != 1) begin n_fail++; $display("FAIL wr_pulse_count: got %0d want 1", strobes); end
        n_run++; if (got_data !== 8'h3C) begin n_fail++; $display("FAIL wr_data: got %h want 3C", got_data); end
        n_run++; if (got_src !== 2'b10) begin n_fail++; $display("FAIL wr_src: got %b want 10", got_src); end
        sel_n = 2'b11; data_in = 8'hFF; strobes = 0;
        for (int t = 0; t < 4; t++) begin
            q3 = 1'b0;
            for (int e = 0; e < 2; e++) begin step(1); if (wr_strobe) strobes++; end
            q3 = 1'b1;
            for (int e = 0; e < 2; e++) begin step(1); if (wr_strobe) strobes++; end
        end
        n_run++; if (strobes != 0) begin n_fail++; $display("FAIL wr_no_repeat: got %0d want 0", strobes); end
        n_run++; if (wr_data !== 8'h3C) begin n_fail++; $display("FAIL wr_data_hold: got %h want 3C", wr_data); end
        rw = 1'b1;
        step(4);
    endtask

    task automatic test_conflict();
        src_rd_ok = 2'b00; sel_n = 2'b00;
        step(1);
        sel_n = 2'b11;
        step(3);
        n_run++; if (conflict !== 1'b1) begin n_fail++; $display("FAIL conf_set: got %b want 1", conflict); end
        conflict_clr = 1'b1;
        step(1);
        n_run++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL conf_clr: got %b want 0", conflict); end
        conflict_clr = 1'b0;
        src_rd_ok = 2'b11; src_data = 16'h2211; sel_n = 2'b00;
        step(5);
        n_run++; if (data_oe !== 1'b1) begin n_fail++; $display("FAIL conf_arb_oe: got %b want 1", data_oe); end
        n_run++; if (data_out !== 8'h11) begin n_fail++; $display("FAIL conf_arb_dout: got %h want 11", data_out); end
        conflict_clr = 1'b1;
        step(2);
        n_run++; if (conflict !== 1'b1) begin n_fail++; $display("FAIL conf_set_wins: got %b want 1", conflict); end
        sel_n = 2'b11;
        step(4);
        n_run++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL conf_clr_held: got %b want 0", conflict); end
        conflict_clr = 1'b0;
        step(6);
    endtask

    task automatic test_glitch();
        src_rd_ok = 2'b01; src_data = 16'h0077; sel_n = 2'b10;
        step(1);
        sel_n = 2'b11;
        for (int e = 1; e <= 12; e++) begin
            step(1);
            n_run++;
            if (data_oe !== 1'b0) begin n_fail++; $display("FAIL glitch_oe edge %0d: got %b want 0", e, data_oe); end
        end
    endtask

    task automatic test_reset_drive();
        sel_n = 2'b10; q3 = 1'b0;
        step(8);
        n_run++; if (data_oe !== 1'b1) begin n_fail++; $display("FAIL rstd_pre_oe: got %b want 1", data_oe); end
        n_run++; if (en245_n !== 1'b0) begin n_fail++; $display("FAIL rstd_pre_en245: got %b want 0", en245_n); end
        #2 reset = 1'b1;
        #1;
        n_run++; if (data_oe !== 1'b0) begin n_fail++; $display("FAIL rstd_async_oe: got %b want 0", data_oe); end
        n_run++; if (en245_n !== 1'b1) begin n_fail++; $display("FAIL rstd_async_en245: got %b want 1", en245_n); end
        step(1);
        reset = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            step(1);
            n_run++;
            if (data_oe !== (e == 5)) begin
                n_fail++; $display("FAIL rstd_relat edge %0d: got %b want %b", e, data_oe, (e == 5));
            end
        end
        n_run++; if (data_out !== 8'h77) begin n_fail++; $display("FAIL rstd_dout: got %h want 77", data_out); end
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_release_turn();
        test_write_commit();
        test_conflict();
        test_glitch();
        test_reset_drive();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
